uart_csr_bridge: RTL and testbench

- Host-facing command bridge that sits on the internal byte interface of the UART block, on the far side of the serial link from the host.
- It parses command frames arriving from the UART receiver, issues CSR write or read transactions as bus initiator, and returns the response frame through the UART transmitter.
- It is the initiator counterpart of the CSR responder port, which lets register access run over the serial line.

---
 rtl/uart_csr_bridge_if.sv | 34 +++
 rtl/uart_csr_bridge.sv | 174 +++++++++++++++++
 tb/tb_uart_csr_bridge.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_csr_bridge_if.sv
// Byte-stream (UART side) and CSR initiator signals of the command bridge.
// The bridge drives the CSR bus, so it takes the master modport; the
// environment (UART + CSR responder) takes the slave modport.
interface uart_csr_bridge_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic [7:0]        rx_data;
   logic              rx_data_valid;
   logic [7:0]        tx_data;
   logic              send;
   logic              tx_data_ready;
   logic [ADDR_W-1:0] csr_wr_addr;
   logic [DATA_W-1:0] csr_wr_data;
   logic              csr_wen;
   logic [ADDR_W-1:0] csr_rd_addr;
   logic              csr_ren;
   logic [DATA_W-1:0] csr_rd_data;
   logic              busy;
   logic [2:0]        err_flags;
   logic              err_clr;

   modport master (
      input  rx_data, rx_data_valid, tx_data_ready, csr_rd_data, err_clr,
      output tx_data, send, csr_wr_addr, csr_wr_data, csr_wen,
             csr_rd_addr, csr_ren, busy, err_flags
   );

   modport slave (
      output rx_data, rx_data_valid, tx_data_ready, csr_rd_data, err_clr,
      input  tx_data, send, csr_wr_addr, csr_wr_data, csr_wen,
             csr_rd_addr, csr_ren, busy, err_flags
   );
endinterface

// File: rtl/uart_csr_bridge.sv
// Command bridge: parses write/read frames from the UART receiver, issues
// the CSR access and returns the response frame through the transmitter.
module uart_csr_bridge #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 16,
   parameter int TIMEOUT_CYC = 100000
) (
   input logic                clk,
   input logic                rst,
   uart_csr_bridge_if.master  bus
);
   localparam int NB = DATA_W / 8;
   localparam int CW = $clog2(NB + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [7:0] OP_WR   = 8'h57;
   localparam logic [7:0] OP_RD   = 8'h52;
   localparam logic [7:0] RSP_ACK = 8'h4B;
   localparam logic [7:0] RSP_ERR = 8'h45;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_WDATA, S_WR, S_RD, S_RDW, S_TX
   } state_t;

   state_t            state_q, state_d;
   logic              is_wr_q, is_wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic [DATA_W-1:0] resp_q, resp_d;
   logic [CW-1:0]     rem_q, rem_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [2:0]        err_q, err_d;
   logic [DATA_W-1:0] data_sh;

   // incoming write data byte shifted in at the LSB end (frame is MSB first)
   assign data_sh = (data_q << 8) | DATA_W'(bus.rx_data);

   // state and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         is_wr_q   <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         cnt_q     <= '0;
         tmo_q     <= '0;
         resp_q    <= '0;
         rem_q     <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rd_addr_q <= '0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         is_wr_q   <= is_wr_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
         resp_q    <= resp_d;
         rem_q     <= rem_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         rd_addr_q <= rd_addr_d;
         err_q     <= err_d;
      end
   end

   // frame parser, CSR sequencing, response shifter and error flags
   always_comb begin
      state_d   = state_q;
      is_wr_d   = is_wr_q;
      addr_d    = addr_q;
      data_d    = data_q;
      cnt_d     = cnt_q;
      tmo_d     = tmo_q;
      resp_d    = resp_q;
      rem_d     = rem_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      rd_addr_d = rd_addr_q;
      // clear first so that any set below wins over a same-cycle clear
      err_d     = bus.err_clr ? 3'b000 : err_q;

      case (state_q)
         S_IDLE: begin
            tmo_d = '0;
            cnt_d = '0;
            if (bus.rx_data_valid) begin
               if (bus.rx_data == OP_WR || bus.rx_data == OP_RD) begin
                  is_wr_d = (bus.rx_data == OP_WR);
                  state_d = S_ADDR;
               end else begin
                  resp_d   = DATA_W'(RSP_ERR) << (DATA_W - 8);
                  rem_d    = CW'(1);
                  err_d[0] = 1'b1;
                  state_d  = S_TX;
               end
            end
         end
         S_ADDR: begin
            if (bus.rx_data_valid) begin
               addr_d  = bus.rx_data[ADDR_W-1:0];
               tmo_d   = '0;
               cnt_d   = '0;
               state_d = is_wr_q ? S_WDATA : S_RD;
               // read address changes only on entry to the strobe cycle
               if (!is_wr_q) rd_addr_d = bus.rx_data[ADDR_W-1:0];
            end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
               err_d[1] = 1'b1;
               tmo_d    = '0;
               state_d  = S_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_WDATA: begin
            if (bus.rx_data_valid) begin
               data_d = data_sh;
               cnt_d  = cnt_q + 1'b1;
               tmo_d  = '0;
               if (cnt_q == CW'(NB - 1)) begin
                  wr_addr_d = addr_q;
                  wr_data_d = data_sh;
                  state_d   = S_WR;
               end
            end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
               err_d[1] = 1'b1;
               tmo_d    = '0;
               state_d  = S_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_WR: begin
            resp_d  = DATA_W'(RSP_ACK) << (DATA_W - 8);
            rem_d   = CW'(1);
            state_d = S_TX;
         end
         S_RD:  state_d = S_RDW;
         S_RDW: begin
            resp_d  = bus.csr_rd_data;
            rem_d   = CW'(NB);
            state_d = S_TX;
         end
         S_TX: begin
            if (bus.tx_data_ready) begin
               resp_d = resp_q << 8;
               rem_d  = rem_q - 1'b1;
               if (rem_q == CW'(1)) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // bytes arriving while the bridge cannot parse them are discarded
      if (bus.rx_data_valid && (state_q inside {S_WR, S_RD, S_RDW, S_TX}))
         err_d[2] = 1'b1;
   end

   assign bus.send        = (state_q == S_TX);
   assign bus.tx_data     = resp_q[DATA_W-1 -: 8];
   assign bus.csr_wen     = (state_q == S_WR);
   assign bus.csr_ren     = (state_q == S_RD);
   assign bus.csr_wr_addr = wr_addr_q;
   assign bus.csr_wr_data = wr_data_q;
   assign bus.csr_rd_addr = rd_addr_q;
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.err_flags   = err_q;
endmodule

// File: tb/tb_uart_csr_bridge.sv
// Directed bench for uart_csr_bridge: write, read, backpressure, bad opcode,
// timeout, dropped bytes, back-to-back frames and mid-frame reset.
module tb_uart_csr_bridge;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
   localparam int TMO    = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vecs = 0;
   int   errs = 0;
   int   wen_cnt = 0;
   int   ren_cnt = 0;
   logic [7:0]  txq[$];
   logic [15:0] model_val = 16'h0000;

   uart_csr_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   uart_csr_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // CSR responder model (data valid the cycle after csr_ren) and monitors
   always @(posedge clk) begin
      if (bus.csr_ren) bus.csr_rd_data <= model_val;
      if (bus.csr_wen) wen_cnt++;
      if (bus.csr_ren) ren_cnt++;
      if (bus.send && bus.tx_data_ready) txq.push_back(bus.tx_data);
   end

   task automatic clear_mon();
      wen_cnt = 0;
      ren_cnt = 0;
      txq.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.rx_data       = b;
      bus.rx_data_valid = 1'b1;
      @(negedge clk);
      bus.rx_data_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.busy !== 1'b0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      vecs++;
      if (bus.busy !== 1'b0) begin
         errs++;
         $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", bus.busy, n);
      end
   endtask

   task automatic clr_err();
      @(negedge clk);
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      vecs++;
      if ({bus.send, bus.csr_wen, bus.csr_ren, bus.busy} !== 4'b0 || bus.tx_data !== 8'h00 ||
          bus.err_flags !== 3'b000 || bus.csr_wr_addr !== 8'h00 || bus.csr_wr_data !== 16'h0000 ||
          bus.csr_rd_addr !== 8'h00) begin
         errs++;
         $display("FAIL reset_state: send=%b wen=%b ren=%b busy=%b tx=%h err=%b wa=%h wd=%h ra=%h, required all 0",
                  bus.send, bus.csr_wen, bus.csr_ren, bus.busy, bus.tx_data, bus.err_flags,
                  bus.csr_wr_addr, bus.csr_wr_data, bus.csr_rd_addr);
      end
      rst = 1'b0;
   endtask

   task automatic test_write(input logic [7:0] a, input logic [15:0] d);
      clear_mon();
      send_byte(8'h57); send_byte(a); send_byte(d[15:8]); send_byte(d[7:0]);
      vecs++;
      if (bus.csr_wen !== 1'b1 || bus.csr_wr_addr !== a || bus.csr_wr_data !== d) begin
         errs++;
         $display("FAIL write_strobe: wen=%b addr=%h data=%h, required 1 %h %h",
                  bus.csr_wen, bus.csr_wr_addr, bus.csr_wr_data, a, d);
      end
      @(negedge clk);
      vecs++;
      if (bus.send !== 1'b1 || bus.tx_data !== 8'h4B || bus.csr_wen !== 1'b0) begin
         errs++;
         $display("FAIL write_ack_latency: send=%b tx=%h wen=%b, required 1 4b 0",
                  bus.send, bus.tx_data, bus.csr_wen);
      end
      wait_idle();
      vecs++;
      if (wen_cnt != 1 || txq.size() != 1) begin
         errs++;
         $display("FAIL write_counts: wen pulses=%0d tx bytes=%0d, required 1 1", wen_cnt, txq.size());
      end else if (txq[0] !== 8'h4B) begin
         errs++;
         $display("FAIL write_resp: got %h, required 4b", txq[0]);
      end
   endtask

   task automatic test_read();
      clear_mon();
      model_val = 16'h1234;
      send_byte(8'h52); send_byte(8'h20);
      vecs++;
      if (bus.csr_ren !== 1'b1 || bus.csr_rd_addr !== 8'h20) begin
         errs++;
         $display("FAIL read_strobe: ren=%b addr=%h, required 1 20", bus.csr_ren, bus.csr_rd_addr);
      end
      @(negedge clk);
      vecs++;
      if (bus.send !== 1'b0 || bus.csr_ren !== 1'b0) begin
         errs++;
         $display("FAIL read_rdw: send=%b ren=%b, required 0 0", bus.send, bus.csr_ren);
      end
      @(negedge clk);
      vecs++;
      if (bus.send !== 1'b1 || bus.tx_data !== 8'h12) begin
         errs++;
         $display("FAIL read_first_byte: send=%b tx=%h, required 1 12", bus.send, bus.tx_data);
      end
      wait_idle();
      vecs++;
      if (wen_cnt != 0 || ren_cnt != 1 || txq.size() != 2) begin
         errs++;
         $display("FAIL read_counts: wen=%0d ren=%0d tx bytes=%0d, required 0 1 2", wen_cnt, ren_cnt, txq.size());
      end else if (txq[0] !== 8'h12 || txq[1] !== 8'h34) begin
         errs++;
         $display("FAIL read_resp: got %h %h, required 12 34", txq[0], txq[1]);
      end
   endtask

   task automatic test_backpressure();
      int bad;
      clear_mon();
      model_val = 16'h1234;
      bus.tx_data_ready = 1'b0;
      send_byte(8'h52); send_byte(8'h21);
      @(negedge clk);
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         if (bus.send !== 1'b1 || bus.tx_data !== 8'h12) bad++;
         @(negedge clk);
      end
      vecs++;
      if (bad != 0) begin
         errs++;
         $display("FAIL backpressure_hold: %0d of 50 cycles lost send/tx_data, required 0", bad);
      end
      bus.tx_data_ready = 1'b1;
      wait_idle();
      vecs++;
      if (txq.size() != 2) begin
         errs++;
         $display("FAIL backpressure_count: tx bytes=%0d, required 2", txq.size());
      end else if (txq[0] !== 8'h12 || txq[1] !== 8'h34) begin
         errs++;
         $display("FAIL backpressure_order: got %h %h, required 12 34", txq[0], txq[1]);
      end
   endtask

   task automatic test_bad_opcode();
      clear_mon();
      send_byte(8'h41);
      wait_idle();
      vecs++;
      if (wen_cnt != 0 || ren_cnt != 0 || txq.size() != 1) begin
         errs++;
         $display("FAIL badop_counts: wen=%0d ren=%0d tx bytes=%0d, required 0 0 1", wen_cnt, ren_cnt, txq.size());
      end else if (txq[0] !== 8'h45) begin
         errs++;
         $display("FAIL badop_resp: got %h, required 45", txq[0]);
      end
      vecs++;
      if (bus.err_flags !== 3'b001) begin
         errs++;
         $display("FAIL badop_flag: err=%b, required 001", bus.err_flags);
      end
      clr_err();
      vecs++;
      if (bus.err_flags !== 3'b000) begin
         errs++;
         $display("FAIL err_clr: err=%b, required 000", bus.err_flags);
      end
   endtask

   task automatic test_timeout();
      clear_mon();
      send_byte(8'h57); send_byte(8'h10); send_byte(8'hAA);
      repeat (59) @(negedge clk);
      vecs++;
      if (bus.busy !== 1'b1 || bus.err_flags !== 3'b000) begin
         errs++;
         $display("FAIL timeout_early: busy=%b err=%b, required 1 000", bus.busy, bus.err_flags);
      end
      repeat (10) @(negedge clk);
      vecs++;
      if (bus.busy !== 1'b0 || bus.err_flags !== 3'b010 || wen_cnt != 0 || txq.size() != 0) begin
         errs++;
         $display("FAIL timeout_fire: busy=%b err=%b wen=%0d tx bytes=%0d, required 0 010 0 0",
                  bus.busy, bus.err_flags, wen_cnt, txq.size());
      end
      clr_err();
      test_write(8'h11, 16'h1234);
   endtask

   task automatic test_drop();
      clear_mon();
      model_val = 16'hCAFE;
      bus.tx_data_ready = 1'b0;
      send_byte(8'h52); send_byte(8'h22);
      @(negedge clk);
      send_byte(8'h99);
      vecs++;
      if (bus.err_flags !== 3'b100 || bus.send !== 1'b1 || bus.tx_data !== 8'hCA) begin
         errs++;
         $display("FAIL drop_flag: err=%b send=%b tx=%h, required 100 1 ca", bus.err_flags, bus.send, bus.tx_data);
      end
      bus.tx_data_ready = 1'b1;
      wait_idle();
      vecs++;
      if (txq.size() != 2) begin
         errs++;
         $display("FAIL drop_count: tx bytes=%0d, required 2", txq.size());
      end else if (txq[0] !== 8'hCA || txq[1] !== 8'hFE) begin
         errs++;
         $display("FAIL drop_resp: got %h %h, required ca fe", txq[0], txq[1]);
      end
      clr_err();
   endtask

   task automatic test_back_to_back();
      clear_mon();
      model_val = 16'h5A3C;
      send_byte(8'h52); send_byte(8'h23);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      // last transfer cycle: this byte must be dropped
      bus.rx_data       = 8'h52;
      bus.rx_data_valid = 1'b1;
      @(negedge clk);
      bus.rx_data_valid = 1'b0;
      vecs++;
      if (bus.busy !== 1'b0 || bus.err_flags !== 3'b100) begin
         errs++;
         $display("FAIL b2b_drop: busy=%b err=%b, required 0 100", bus.busy, bus.err_flags);
      end
      clr_err();
      clear_mon();
      send_byte(8'h52); send_byte(8'h24);
      wait_idle();
      vecs++;
      if (txq.size() != 2) begin
         errs++;
         $display("FAIL b2b_count: tx bytes=%0d, required 2", txq.size());
      end else if (txq[0] !== 8'h5A || txq[1] !== 8'h3C) begin
         errs++;
         $display("FAIL b2b_resp: got %h %h, required 5a 3c", txq[0], txq[1]);
      end
   endtask

   task automatic test_reset_mid();
      send_byte(8'h41);
      send_byte(8'h57); send_byte(8'h30); send_byte(8'hAA);
      @(negedge clk);
      rst = 1'b1;
      #1;
      vecs++;
      if ({bus.send, bus.csr_wen, bus.csr_ren, bus.busy} !== 4'b0 || bus.tx_data !== 8'h00 ||
          bus.err_flags !== 3'b000 || bus.csr_wr_addr !== 8'h00 || bus.csr_wr_data !== 16'h0000 ||
          bus.csr_rd_addr !== 8'h00) begin
         errs++;
         $display("FAIL reset_mid: send=%b wen=%b ren=%b busy=%b tx=%h err=%b wa=%h wd=%h ra=%h, required all 0",
                  bus.send, bus.csr_wen, bus.csr_ren, bus.busy, bus.tx_data, bus.err_flags,
                  bus.csr_wr_addr, bus.csr_wr_data, bus.csr_rd_addr);
      end
      @(negedge clk);
      rst = 1'b0;
      test_write(8'h40, 16'h5678);
   endtask

   initial begin
      bus.rx_data       = 8'h00;
      bus.rx_data_valid = 1'b0;
      bus.tx_data_ready = 1'b1;
      bus.err_clr       = 1'b0;
      bus.csr_rd_data   = 16'h0000;
      test_reset();
      test_write(8'h10, 16'hBEEF);
      test_read();
      test_backpressure();
      test_bad_opcode();
      test_timeout();
      test_drop();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
